// File: rtl/coin_acceptor_if.sv
// Coin acceptor sensor/vend-controller bundle.
// slave = acceptor side, master = the sensors and vend controller side.
interface coin_acceptor_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;

    logic          nickel_sense;
    logic          dime_sense;
    logic [1:0]    coin;
    logic          reject;
    logic          overflow;
    logic [PW-1:0] pending;

    modport master (
        output nickel_sense,
        output dime_sense,
        input  coin,
        input  reject,
        input  overflow,
        input  pending
    );

    modport slave (
        input  nickel_sense,
        input  dime_sense,
        output coin,
        output reject,
        output overflow,
        output pending
    );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: sync + debounce two slot sensors, queue coin events,
// and emit one-cycle coin codes separated by an idle gap.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input logic            clock,
    input logic            reset,
    coin_acceptor_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [7:0]    CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] FULL     = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    // bit 0 = nickel channel, bit 1 = dime channel
    logic [1:0]      raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      lvl_q, lvl_d;
    logic [1:0]      ev_q, ev_d;
    logic [1:0][7:0] cnt_q, cnt_d;

    state_t     state_q, state_d;
    logic [3:0] gcnt_q, gcnt_d;
    logic [1:0] coin_q, coin_d;
    logic       reject_q, reject_d;
    logic       overflow_q, overflow_d;

    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [PW-1:0] count_q, count_d;

    logic       pop, push, drop, both, one;
    logic [1:0] code;

    assign raw = {bus.dime_sense, bus.nickel_sense};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            ev_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            ev_q    <= ev_d;
            cnt_q   <= cnt_d;
        end
    end

    // An event fires only when a channel's debounced level toggles up.
    always_comb begin
        lvl_d = lvl_q;
        ev_d  = '0;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    lvl_d[i] = ~lvl_q[i];
                    ev_d[i]  = ~lvl_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign both = &ev_q;
    assign one  = ^ev_q;
    assign code = ev_q[1] ? 2'b10 : 2'b01;
    assign pop  = (state_q == IDLE) && (count_q != '0);
    assign push = one && ((count_q != FULL) || pop);
    assign drop = one && (count_q == FULL) && !pop;

    assign reject_d   = both || drop;
    assign overflow_d = overflow_q || drop;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + PW'(1);
        end else if (pop && !push) begin
            count_d = count_q - PW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            reject_q   <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else begin
            if (push) begin
                mem_q[wr_q] <= code;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            count_q    <= count_d;
            reject_q   <= reject_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gcnt_q  <= '0;
            coin_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            coin_q  <= coin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        coin_d  = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    coin_d  = mem_q[rd_q];
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                gcnt_d  = '0;
                state_d = GAP;
            end
            GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.coin     = coin_q;
    assign bus.reject   = reject_q;
    assign bus.overflow = overflow_q;
    assign bus.pending  = count_q;
endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: windowed debounce model, FIFO/timing model,
// and a code scoreboard drained by an independent monitor.
module tb_coin_acceptor;
    localparam int DEB   = 4;
    localparam int GAP   = 15;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    coin_acceptor_if #(.FIFO_DEPTH(DEPTH)) bus ();

    coin_acceptor #(
        .DEBOUNCE_CYCLES(DEB),
        .GAP_CYCLES     (GAP),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference model state
    logic [1:0] exp_q[$];
    logic [1:0] fq[$];
    logic [1:0] got_q[$];
    bit wn[$], wd[$];
    bit pn1, pn2, pd1, pd2, lvn, lvd, evn, evd;
    bit m_rej, m_ovf, m_coinv;
    int m_edge, next_pop;

    function automatic bit all_diff(input bit q[$], input bit lvl);
        if (q.size() != DEB) return 1'b0;
        foreach (q[i]) if (q[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete(); fq.delete(); wn.delete(); wd.delete();
            {pn1, pn2, pd1, pd2, lvn, lvd, evn, evd} = '0;
            {m_rej, m_ovf, m_coinv} = '0;
            m_edge = 0; next_pop = 0;
        end else begin
            bit yn, yd;
            m_edge++;
            m_coinv = 1'b0;
            if (fq.size() > 0 && m_edge >= next_pop) begin
                void'(fq.pop_front());
                m_coinv  = 1'b1;
                next_pop = m_edge + GAP + 2;
            end
            m_rej = 1'b0;
            if (evn && evd) begin
                m_rej = 1'b1;
            end else if (evn || evd) begin
                if (fq.size() < DEPTH) begin
                    fq.push_back(evd ? 2'b10 : 2'b01);
                    exp_q.push_back(evd ? 2'b10 : 2'b01);
                end else begin
                    m_rej = 1'b1;
                    m_ovf = 1'b1;
                end
            end
            yn = pn2; pn2 = pn1; pn1 = bus.nickel_sense;
            yd = pd2; pd2 = pd1; pd1 = bus.dime_sense;
            wn.push_back(yn);
            if (wn.size() > DEB) void'(wn.pop_front());
            wd.push_back(yd);
            if (wd.size() > DEB) void'(wd.pop_front());
            evn = 1'b0;
            evd = 1'b0;
            if (all_diff(wn, lvn)) begin
                lvn = !lvn; wn.delete(); evn = lvn;
            end
            if (all_diff(wd, lvd)) begin
                lvd = !lvd; wd.delete(); evd = lvd;
            end
        end
    end

    int coin_seen = 0;
    int rej_seen  = 0;
    int maxpend   = 0;
    int zeros     = 1000;
    bit prev_nz   = 1'b0;

    // Per-cycle status against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("pending", int'(bus.pending), fq.size());
            check("reject", int'(bus.reject), int'(m_rej));
            check("overflow", int'(bus.overflow), int'(m_ovf));
            check("coin_timing", int'(bus.coin != 2'b00), int'(m_coinv));
            if (int'(bus.pending) > maxpend) maxpend = int'(bus.pending);
            if (bus.reject) rej_seen++;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_nz = 1'b0;
            zeros   = 1000;
        end else if (bus.coin != 2'b00) begin
            coin_seen++;
            got_q.push_back(bus.coin);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_code actual=%0d required=none", bus.coin);
            end else begin
                check("code", int'(bus.coin), int'(exp_q.pop_front()));
            end
            check("one_cycle", int'(prev_nz), 0);
            check("gap_ok", int'(zeros >= GAP), 1);
            zeros   = 0;
            prev_nz = 1'b1;
        end else begin
            zeros++;
            prev_nz = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int first, base_c, base_r, hn, hd;
        bit found;
        logic [1:0] seq [3];
        bus.nickel_sense = 1'b0;
        bus.dime_sense   = 1'b0;
        cyc(3);
        check("rst_coin", int'(bus.coin), 0);
        check("rst_reject", int'(bus.reject), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_pending", int'(bus.pending), 0);

        // Nickel held high across reset release: latency and single cycle
        bus.nickel_sense = 1'b1;
        cyc(1);
        rst = 1'b0;
        first = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (bus.coin != 2'b00) begin
                first = e;
                break;
            end
        end
        check("latency_edge", first, DEB + 4);
        check("latency_code", int'(bus.coin), 1);
        @(posedge clk);
        #1;
        check("latency_one_cycle", int'(bus.coin), 0);
        cyc(2);
        bus.nickel_sense = 1'b0;
        cyc(30);
        check("single_pending", int'(bus.pending), 0);
        check("single_no_reject", rej_seen, 0);

        // Bounce shorter than the debounce window
        base_c = coin_seen;
        base_r = rej_seen;
        for (int w = 1; w <= 3; w++) begin
            bus.nickel_sense = 1'b1;
            cyc(w);
            bus.nickel_sense = 1'b0;
            cyc(8);
        end
        cyc(10);
        check("bounce_coin", coin_seen - base_c, 0);
        check("bounce_reject", rej_seen - base_r, 0);

        // Ordered sequence nickel, nickel, dime
        got_q.delete();
        seq[0] = 2'b01; seq[1] = 2'b01; seq[2] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            bus.nickel_sense = seq[i][0];
            bus.dime_sense   = seq[i][1];
            cyc(6);
            bus.nickel_sense = 1'b0;
            bus.dime_sense   = 1'b0;
            cyc(6);
        end
        cyc(60);
        check("seq_count", got_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            logic [1:0] g;
            g = (i < got_q.size()) ? got_q[i] : 2'b00;
            check("seq_code", int'(g), int'(seq[i]));
        end

        // Simultaneous nickel and dime
        base_c = coin_seen;
        base_r = rej_seen;
        bus.nickel_sense = 1'b1;
        bus.dime_sense   = 1'b1;
        cyc(8);
        bus.nickel_sense = 1'b0;
        bus.dime_sense   = 1'b0;
        cyc(20);
        check("both_reject", rej_seen - base_r, 1);
        check("both_coin", coin_seen - base_c, 0);
        check("both_pending", int'(bus.pending), 0);

        // Events faster than the drain rate fill the queue
        maxpend = 0;
        base_r  = rej_seen;
        for (int i = 0; i < 5; i++) begin
            bus.nickel_sense = 1'b1;
            bus.dime_sense   = 1'b0;
            cyc(DEB);
            bus.nickel_sense = 1'b0;
            bus.dime_sense   = 1'b1;
            cyc(DEB);
        end
        bus.dime_sense = 1'b0;
        cyc(6);
        check("ovf_maxpend", maxpend, DEPTH);
        check("ovf_flag", int'(bus.overflow), 1);
        check("ovf_reject", int'(rej_seen - base_r >= 1), 1);

        // Reset while a code is on the bus
        found = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.coin != 2'b00) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_found", int'(found), 1);
        check("mid_pending_nz", int'(bus.pending != 0), 1);
        check("mid_overflow_sticky", int'(bus.overflow), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_coin", int'(bus.coin), 0);
        check("mid_rst_pending", int'(bus.pending), 0);
        check("mid_rst_overflow", int'(bus.overflow), 0);
        check("mid_rst_reject", int'(bus.reject), 0);
        cyc(2);
        rst    = 1'b0;
        base_c = coin_seen;
        cyc(80);
        check("mid_no_codes", coin_seen - base_c, 0);

        // Random sensor activity
        hn = 0;
        hd = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hn == 0) begin
                bus.nickel_sense = 1'($urandom_range(0, 1));
                hn = $urandom_range(1, 14);
            end
            if (hd == 0) begin
                bus.dime_sense = 1'($urandom_range(0, 1));
                hd = $urandom_range(1, 14);
            end
            hn--;
            hd--;
            cyc(1);
        end
        bus.nickel_sense = 1'b0;
        bus.dime_sense   = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (exp_q.size() == 0 && fq.size() == 0) break;
            cyc(1);
        end
        cyc(20);
        check("drain_scoreboard", exp_q.size(), 0);
        check("drain_pending", int'(bus.pending), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
